alu_cmd_sequencer: RTL

Command front-end for the 8-bit ALU top. It sits directly upstream of the ALU and accepts operation commands (op, a, b) over a valid/ready interface into a small FIFO. It issues each command to the ALU as a single start pulse, holding operands stable until the ALU signals done. It then returns the 16-bit result over a valid/ready response interface, with a timeout watchdog and illegal-op rejection.

---
 rtl/alu_cmd_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 8-bit ALU: buffers (op, a, b) commands in a FIFO,
// issues each as a single start pulse, and returns the result with error flagging.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [15:0] alu_result,
  input  logic        alu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Both interfaces use strict valid/ready: a transfer happens on a rising edge
  // where valid and ready are both high; valid never waits on ready, and payload
  // stays stable while valid is high and ready is low.

  state_t        state_q;
  logic [18:0]   mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] tmo_q;
  logic          alu_start_q;
  logic [2:0]    alu_op_q;
  logic [7:0]    alu_a_q;
  logic [7:0]    alu_b_q;
  logic          rsp_valid_q;
  logic [15:0]   rsp_result_q;
  logic [2:0]    rsp_op_q;
  logic          rsp_err_q;

  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic [18:0] head;

  // Extra MSB on the pointers distinguishes full from empty when indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready  = !fifo_full && !reset;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tmo_q        <= '0;
      alu_start_q  <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      case (state_q)
        IDLE: begin
          if (pop) begin
            alu_op_q <= head[18:16];
            alu_a_q  <= head[15:8];
            alu_b_q  <= head[7:0];
            if (head[18:16] == OP_ILLEGAL) begin
              rsp_valid_q  <= 1'b1;
              rsp_err_q    <= 1'b1;
              rsp_result_q <= '0;
              rsp_op_q     <= OP_ILLEGAL;
              state_q      <= RESP;
            end else begin
              alu_start_q <= 1'b1;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          alu_start_q <= 1'b0;
          tmo_q       <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (alu_done) begin
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= alu_result;
            rsp_op_q     <= alu_op_q;
            state_q      <= RESP;
          end else if (tmo_q == CW'(TIMEOUT - 1)) begin
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= 1'b1;
            rsp_result_q <= '0;
            rsp_op_q     <= alu_op_q;
            state_q      <= RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_start  = alu_start_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign dbg_state  = state_q;

endmodule
